// File: rtl/stats_drain_if.sv
// stats_drain_if: TX word handshake between the stats drain and the UART.
//   tx_word  : word offered to the UART, held while tx_valid is high
//   tx_valid : tx_word is valid
//   tx_ack   : UART accepted tx_word (meaningful only with tx_valid)
interface stats_drain_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0] tx_word;
    logic             tx_valid;
    logic             tx_ack;
    modport master (output tx_word, tx_valid, input tx_ack);
    modport slave  (input tx_word, tx_valid, output tx_ack);
endinterface

// File: rtl/stats_drain.sv
// stats_drain: drains the stats shift chain to the UART as header, data words, checksum.
//   clock, reset : system clock, asynchronous active-high reset
//   enable       : low freezes the block (stats_shift/done forced low)
//   start        : drain request
//   stats_word   : head of the stats chain; stats_shift advances it
//   tx           : TX word handshake (master side)
//   busy         : not idle; done: pulse after trailer accepted
//   error        : sticky, start seen while busy
module stats_drain #(
    parameter int               WIDTH       = 16,
    parameter int               NUM_WORDS   = 64,
    parameter int               CNT_W       = 10,
    parameter logic [WIDTH-1:0] HEADER_WORD = 16'hD5A7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [WIDTH-1:0] stats_word,
    output logic             stats_shift,
    output logic             busy,
    output logic             done,
    output logic             error,
    stats_drain_if.master    tx
);
    typedef enum logic [2:0] {IDLE, HSEND, LOAD, SEND, WAIT, CSEND} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] word_q, word_d, sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d, shift_q, shift_d;
    logic             busy_q, busy_d, done_q, done_d, error_q, error_d;

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        error_d = error_q;
        shift_d = 1'b0;
        done_d  = 1'b0;
        if (enable) begin
            // a start that arrives while any drain is in flight only flags an error
            if (start && state_q != IDLE)
                error_d = 1'b1;
            case (state_q)
                IDLE: if (start) begin
                    word_d  = HEADER_WORD;
                    valid_d = 1'b1;
                    sum_d   = '0;
                    cnt_d   = '0;
                    error_d = 1'b0;
                    state_d = HSEND;
                end
                HSEND: if (tx.tx_ack) begin
                    valid_d = 1'b0;
                    state_d = LOAD;
                end
                LOAD: begin
                    word_d  = stats_word;
                    valid_d = 1'b1;
                    sum_d   = sum_q + stats_word;
                    state_d = SEND;
                end
                SEND: if (tx.tx_ack) begin
                    valid_d = 1'b0;
                    shift_d = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = WAIT;
                end
                // one idle cycle lets the chain settle after the shift pulse
                WAIT: if (cnt_q == CNT_W'(NUM_WORDS)) begin
                    word_d  = sum_q;
                    valid_d = 1'b1;
                    state_d = CSEND;
                end else begin
                    state_d = LOAD;
                end
                CSEND: if (tx.tx_ack) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d != IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            word_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign tx.tx_word   = word_q;
    assign tx.tx_valid  = valid_q;
    assign stats_shift  = shift_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = error_q;
endmodule

// File: tb/tb_stats_drain.sv
// tb_stats_drain: scoreboard bench for stats_drain (NUM_WORDS=4 and NUM_WORDS=2 instances).
module tb_stats_drain;
    logic        clock = 1'b0, reset = 1'b1, enable = 1'b1, start0 = 1'b0, start1 = 1'b0;
    logic        shift0, busy0, done0, error0, shift1, busy1, done1, error1;
    logic [15:0] chain0 [4];
    logic [15:0] chain1 [2];
    logic [1:0]  ptr0 = 2'd0;
    logic        ptr1 = 1'b0;
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    int          checks = 0, errors = 0, nshift0 = 0, ndone0 = 0, nshift1 = 0, ndone1 = 0;
    int          vc0 = 0, vc1 = 0, b;
    logic        hold0 = 1'b0, tog0 = 1'b0;

    stats_drain_if #(.WIDTH(16)) if0 ();
    stats_drain_if #(.WIDTH(16)) if1 ();

    always #5 clock = ~clock;

    stats_drain #(.NUM_WORDS(4)) u0 (
        .clock(clock), .reset(reset), .enable(enable), .start(start0),
        .stats_word(chain0[ptr0]), .stats_shift(shift0), .busy(busy0),
        .done(done0), .error(error0), .tx(if0));

    stats_drain #(.NUM_WORDS(2)) u1 (
        .clock(clock), .reset(reset), .enable(enable), .start(start1),
        .stats_word(chain1[ptr1]), .stats_shift(shift1), .busy(busy1),
        .done(done1), .error(error1), .tx(if1));

    // stats chain models: rotate on each shift pulse
    always @(posedge clock) begin
        if (shift0) ptr0 <= ptr0 + 2'd1;
        if (shift1) ptr1 <= ~ptr1;
    end

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, got, exp);
        end
    endtask

    // UART models: ack in the second cycle of each valid word
    initial begin
        if0.tx_ack = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (tog0) if0.tx_ack = ~if0.tx_ack;
            else if (hold0 || !if0.tx_valid) begin if0.tx_ack = 1'b0; vc0 = 0; end
            else begin vc0++; if0.tx_ack = (vc0 == 2); end
        end
    end
    initial begin
        if1.tx_ack = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (!if1.tx_valid) begin if1.tx_ack = 1'b0; vc1 = 0; end
            else begin vc1++; if1.tx_ack = (vc1 == 2); end
        end
    end

    // monitors: compare each accepted word against the scoreboard
    initial forever begin
        @(negedge clock);
        if (shift0) nshift0++;
        if (done0) ndone0++;
        if (!reset && enable && if0.tx_valid && if0.tx_ack) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx0_extra got %h want none", if0.tx_word);
            end else chk("tx0_word", {16'd0, if0.tx_word}, {16'd0, q0.pop_front()});
        end
    end
    initial forever begin
        @(negedge clock);
        if (shift1) nshift1++;
        if (done1) ndone1++;
        if (!reset && enable && if1.tx_valid && if1.tx_ack) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL tx1_extra got %h want none", if1.tx_word);
            end else chk("tx1_word", {16'd0, if1.tx_word}, {16'd0, q1.pop_front()});
        end
    end

    task automatic push0(input logic [15:0] a, c, d, e, f, g);
        q0.push_back(a); q0.push_back(c); q0.push_back(d);
        q0.push_back(e); q0.push_back(f); q0.push_back(g);
    endtask

    task automatic pulse(input bit d);
        @(posedge clock); #1;
        if (d) start1 = 1'b1; else start0 = 1'b1;
        @(posedge clock); #1;
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(input bit d, input int lim);
        int k = 0;
        while (k < lim && !(d ? done1 : done0)) begin @(negedge clock); #1; k++; end
        chk(d ? "done1_wait" : "done0_wait", {31'd0, k < lim}, 32'd1);
        @(negedge clock); #1;
    endtask

    task automatic wait_word0(input logic [15:0] w);
        int k = 0;
        while (k < 200 && !(if0.tx_valid && if0.tx_word == w)) begin @(negedge clock); k++; end
        chk("word0_wait", {31'd0, k < 200}, 32'd1);
    endtask

    initial begin
        chain0 = '{16'h1, 16'h2, 16'h3, 16'h4};
        chain1 = '{16'hFFFF, 16'h0002};
        repeat (2) @(negedge clock);
        chk("rst_valid", {31'd0, if0.tx_valid}, 32'd0);
        chk("rst_word", {16'd0, if0.tx_word}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_done", {31'd0, done0}, 32'd0);
        chk("rst_error", {31'd0, error0}, 32'd0);
        chk("rst_shift", {31'd0, shift0}, 32'd0);
        reset = 1'b0;

        // T1 basic drain
        b = nshift0;
        push0(16'hD5A7, 16'h1, 16'h2, 16'h3, 16'h4, 16'h000A);
        pulse(0);
        chk("t1_hdr_valid", {31'd0, if0.tx_valid}, 32'd1);
        chk("t1_busy", {31'd0, busy0}, 32'd1);
        wait_done(0, 300);
        chk("t1_shifts", nshift0 - b, 32'd4);
        chk("t1_dones", ndone0, 32'd1);
        chk("t1_idle", {31'd0, busy0}, 32'd0);
        chk("t1_done_pulse", {31'd0, done0}, 32'd0);
        chk("t1_q_empty", q0.size(), 32'd0);

        // T2 checksum wrap on the two-word instance
        q1.push_back(16'hD5A7); q1.push_back(16'hFFFF);
        q1.push_back(16'h0002); q1.push_back(16'h0001);
        pulse(1);
        wait_done(1, 300);
        chk("t2_shifts", nshift1, 32'd2);
        chk("t2_q_empty", q1.size(), 32'd0);

        // T3 long ack stall on the second data word
        chain0 = '{16'h10, 16'h20, 16'h30, 16'h40};
        b = nshift0;
        push0(16'hD5A7, 16'h10, 16'h20, 16'h30, 16'h40, 16'h00A0);
        pulse(0);
        wait_word0(16'h20);
        hold0 = 1'b1;
        repeat (50) @(negedge clock);
        chk("t3_word_stable", {16'd0, if0.tx_word}, 32'h20);
        chk("t3_valid_held", {31'd0, if0.tx_valid}, 32'd1);
        chk("t3_no_shift", nshift0 - b, 32'd1);
        hold0 = 1'b0;
        wait_done(0, 300);
        chk("t3_shifts", nshift0 - b, 32'd4);
        chk("t3_q_empty", q0.size(), 32'd0);

        // T4 start while busy flags error without disturbing the drain
        chain0 = '{16'h5, 16'h6, 16'h7, 16'h8};
        push0(16'hD5A7, 16'h5, 16'h6, 16'h7, 16'h8, 16'h001A);
        pulse(0);
        wait_word0(16'h6);
        pulse(0);
        chk("t4_error_set", {31'd0, error0}, 32'd1);
        wait_done(0, 300);
        chk("t4_error_sticky", {31'd0, error0}, 32'd1);
        chk("t4_q_empty", q0.size(), 32'd0);
        push0(16'hD5A7, 16'h5, 16'h6, 16'h7, 16'h8, 16'h001A);
        pulse(0);
        chk("t4_error_clr", {31'd0, error0}, 32'd0);
        wait_done(0, 300);
        chk("t4_q_empty2", q0.size(), 32'd0);

        // T5 enable low while in WAIT with ack toggling
        chain0 = '{16'h100, 16'h200, 16'h300, 16'h400};
        b = nshift0;
        push0(16'hD5A7, 16'h100, 16'h200, 16'h300, 16'h400, 16'h0A00);
        pulse(0);
        begin
            int k = 0;
            while (k < 200 && !shift0) begin @(posedge clock); #1; k++; end
            chk("t5_shift_wait", {31'd0, k < 200}, 32'd1);
        end
        enable = 1'b0; tog0 = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        chk("t5_frozen_shift", nshift0 - b, 32'd1);
        chk("t5_frozen_valid", {31'd0, if0.tx_valid}, 32'd0);
        chk("t5_frozen_busy", {31'd0, busy0}, 32'd1);
        tog0 = 1'b0; if0.tx_ack = 1'b0; enable = 1'b1;
        wait_done(0, 300);
        chk("t5_shifts", nshift0 - b, 32'd4);
        chk("t5_q_empty", q0.size(), 32'd0);

        // T6 asynchronous reset mid-drain, then a fresh drain
        chain0 = '{16'h1, 16'h2, 16'h3, 16'h4};
        push0(16'hD5A7, 16'h1, 16'h2, 16'h3, 16'h4, 16'h000A);
        pulse(0);
        wait_word0(16'h2);
        reset = 1'b1;
        #1;
        chk("t6_valid", {31'd0, if0.tx_valid}, 32'd0);
        chk("t6_word", {16'd0, if0.tx_word}, 32'd0);
        chk("t6_busy", {31'd0, busy0}, 32'd0);
        chk("t6_shift", {31'd0, shift0}, 32'd0);
        q0.delete();
        @(negedge clock);
        reset = 1'b0;
        b = nshift0;
        push0(16'hD5A7, 16'h2, 16'h3, 16'h4, 16'h1, 16'h000A);
        pulse(0);
        chk("t6_hdr", {16'd0, if0.tx_word}, 32'hD5A7);
        wait_done(0, 300);
        chk("t6_shifts", nshift0 - b, 32'd4);
        chk("t6_q_empty", q0.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
